// File: rtl/pipelined_adder_tree_acc.sv
// pipelined_adder_tree_acc
//   Pipelined signed adder tree that reduces MATRIX_SIZE partial products to one
//   sum per beat, followed by a saturating accumulator that can either pass each
//   beat's sum straight through or accumulate successive beats until in_last.
//
// Ports
//   clk, rstn      rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready, in_data_flat, in_last, acc_en
//                  input beat handshake; element i at [i*PARTIAL_MUL_BW +: PARTIAL_MUL_BW]
//   out_valid/out_ready, out_sum, out_sat
//                  result handshake; out_sat is sticky across an accumulation group
//
// The tree has LEVELS=ceil(log2(MATRIX_SIZE)) levels over a zero-padded input.
// A register bank follows level L when L%PIPE_EVERY==0 or L==LEVELS. Every stage,
// including the accumulator, holds while the output is stalled.
module pipelined_adder_tree_acc #(
  parameter int PARTIAL_MUL_BW = 16,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 32,
  parameter int PIPE_EVERY     = 2,
  parameter int ACC_BW         = 32
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [PARTIAL_MUL_BW*MATRIX_SIZE-1:0] in_data_flat,
  input  logic                                  in_last,
  input  logic                                  acc_en,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [ACC_BW-1:0]              out_sum,
  output logic                                  out_sat
);

  localparam int LEVELS = $clog2(MATRIX_SIZE);
  localparam int NPAD   = 1 << LEVELS;
  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_BW-1:0] out_sum_q, out_sum_d;
  logic                     out_sat_q, out_sat_d;
  logic signed [ACC_BW-1:0] acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic                     first_q, first_d;
  logic                     stall;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Each level exposes node/vld/lst/ae; level 0 is the sign-extended, padded input.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = NPAD >> l;
    logic signed [PARTIAL_SUM_BW-1:0] node [W];
    logic                             vld, lst, ae;

    if (l == 0) begin : g_in
      for (genvar j = 0; j < W; j++) begin : g_el
        if (j < MATRIX_SIZE) begin : g_real
          logic signed [PARTIAL_MUL_BW-1:0] elem;
          assign elem    = in_data_flat[j*PARTIAL_MUL_BW +: PARTIAL_MUL_BW];
          assign node[j] = PARTIAL_SUM_BW'(elem);
        end else begin : g_pad
          assign node[j] = '0;
        end
      end
      assign vld = in_valid;
      assign lst = in_last;
      assign ae  = acc_en;
    end else begin : g_add
      logic signed [PARTIAL_SUM_BW-1:0] sum_d [W];
      for (genvar j = 0; j < W; j++) begin : g_pair
        assign sum_d[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
      end

      if ((l % PIPE_EVERY == 0) || (l == LEVELS)) begin : g_reg
        logic signed [PARTIAL_SUM_BW-1:0] node_q [W];
        logic                             vld_q, lst_q, ae_q;
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            node_q <= '{default: '0};
            vld_q  <= 1'b0;
            lst_q  <= 1'b0;
            ae_q   <= 1'b0;
          end else if (!stall) begin
            node_q <= sum_d;
            vld_q  <= g_lvl[l-1].vld;
            lst_q  <= g_lvl[l-1].lst;
            ae_q   <= g_lvl[l-1].ae;
          end
        end
        assign node = node_q;
        assign vld  = vld_q;
        assign lst  = lst_q;
        assign ae   = ae_q;
      end else begin : g_comb
        assign node = sum_d;
        assign vld  = g_lvl[l-1].vld;
        assign lst  = g_lvl[l-1].lst;
        assign ae   = g_lvl[l-1].ae;
      end
    end
  end

  logic signed [PARTIAL_SUM_BW-1:0] t_data;
  logic                             t_vld, t_lst, t_ae;
  logic signed [ACC_BW-1:0]         t_ext, base, clamped;
  logic signed [ACC_BW:0]           wide;
  logic                             ovf;

  assign t_data = g_lvl[LEVELS].node[0];
  assign t_vld  = g_lvl[LEVELS].vld;
  assign t_lst  = g_lvl[LEVELS].lst;
  assign t_ae   = g_lvl[LEVELS].ae;

  always_comb begin
    acc_d       = acc_q;
    sat_d       = sat_q;
    first_d     = first_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    // Held while stalled, otherwise drops after the handshake unless a new result lands.
    out_valid_d = stall;

    t_ext   = ACC_BW'(t_data);
    base    = first_q ? '0 : acc_q;
    wide    = (ACC_BW+1)'(base) + (ACC_BW+1)'(t_ext);
    ovf     = wide[ACC_BW] ^ wide[ACC_BW-1];
    clamped = wide[ACC_BW-1:0];
    if (ovf) clamped = wide[ACC_BW] ? ACC_MIN : ACC_MAX;

    if (t_vld && !stall) begin
      if (!t_ae) begin
        // Pass-through beat; also abandons any open accumulation group.
        out_sum_d   = t_ext;
        out_sat_d   = 1'b0;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
      end else begin
        acc_d = clamped;
        sat_d = (~first_q & sat_q) | ovf;
        if (t_lst) begin
          out_sum_d   = clamped;
          out_sat_d   = sat_d;
          out_valid_d = 1'b1;
          first_d     = 1'b1;
        end else begin
          first_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      first_q     <= first_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule
